stage_sequencer: RTL and testbench
==================================

// Module: stage_sequencer
// PURPOSE
//  Parametrised game-flow controller, successor to the fixed 3-mode game controller.
//  Runs a NUM_STAGES-long stage table; each entry selects which enemy kind runs
//  (monsters / asteroids / boss / none).
//  Owns per-kind enables and active-low resets, pause, cheat-skip, a timed
//  inter-stage intermission, and game won/over flags.
//  Sits between the top-level buttons/hit logic and the enemy and player units.
// PARAMETERS
//  NUM_STAGES    4             number of stages; 1..2**STAGE_W
//  STAGE_W       3             width of stage_num
//  STAGE_KIND    8'b10_01_00_00  2 bits per stage, stage i = bits [2i+1:2i];
//                              0=monsters, 1=asteroids, 2=boss, 3=none (player only)
//  INTER_FRAMES  60            startOfFrame pulses spent in intermission; 0 = skip intermission
// PORTS
//  clk              in   1        system clock
//  resetN           in   1        synchronous, active-low reset
//  startOfFrame     in   1        one-cycle frame strobe
//  start_game       in   1        level; rising edge starts or restarts the game
//  pause            in   1        level; high freezes play
//  skip_stage       in   1        level, active-high cheat; rising edge ends the current stage
//  win_stage        in   1        level from the active enemy unit: stage cleared
//  player_dead      in   1        level: player out of lives
//  enable_player    out  1        player unit enable
//  resetN_player    out  1        player unit reset, active-low
//  enable_kind      out  3        [0]=monsters, [1]=asteroids, [2]=boss
//  resetN_kind      out  3        per-kind active-low reset
//  stage_num        out  STAGE_W  current stage, 0-based
//  stage_done_pulse out  1        1-cycle pulse when a stage is won or skipped
//  game_won         out  1        level, held in WON
//  game_over        out  1        level, held in LOST
// BEHAVIOUR
//  Outputs and state are all registered. Start and skip edges are detected from a
//  1-cycle delayed copy of each input.
//  Reset (resetN=0 at posedge):
//   - state=IDLE, stage_num=0, frame counter=0, delayed input copies=0.
//   - all enables 0, resetN_player=0, resetN_kind=3'b000.
//   - stage_done_pulse=0, game_won=0, game_over=0.
//  States:
//   - IDLE:
//     - All enables 0; all unit resets held low.
//     - start rising edge -> LOAD with stage_num=0.
//   - LOAD (exactly 1 cycle):
//     - resetN_kind=000.
//     - resetN_player=0 only when stage_num==0; otherwise 1.
//     - Enables 0. Next state is PLAY with guard=1.
//   - PLAY:
//     - enable_player=1; enable_kind=onehot(STAGE_KIND[stage_num]), 000 for kind 3.
//     - resetN_* all 1.
//     - guard clears after the first PLAY cycle; win_stage is ignored while guard=1
//       (stale flag from the unit being reset).
//     - Priority 1: player_dead -> LOST.
//     - Priority 2: pause -> PAUSED.
//     - Priority 3: (win_stage & !guard) | skip rising edge:
//       - stage_done_pulse=1;
//       - if stage_num==NUM_STAGES-1 -> WON;
//       - else if INTER_FRAMES==0 -> stage_num+1, LOAD;
//       - else -> INTERMISSION with counter=0.
//   - PAUSED:
//     - All enables 0; resets high; unit state is preserved.
//     - player_dead, win_stage and skip are ignored.
//     - pause low -> PLAY; guard is not re-armed.
//   - INTERMISSION:
//     - enable_player=1, enable_kind=000.
//     - Each startOfFrame increments the counter.
//     - When counter==INTER_FRAMES-1 and startOfFrame=1: stage_num+1, -> LOAD.
//     - skip rising edge: stage_num+1, -> LOAD immediately.
//     - pause -> PAUSED_I (same outputs as PAUSED; counter frozen; returns to INTERMISSION).
//   - WON / LOST:
//     - game_won=1 / game_over=1; all enables 0.
//     - start rising edge: clear both flags, stage_num=0, -> LOAD (full restart).
//  Boundaries:
//   - Simultaneous win_stage and player_dead in PLAY -> LOST.
//   - Simultaneous skip and pause -> PAUSED; the skip edge is lost.
//   - NUM_STAGES=1: first completion -> WON directly.
//   - stage_num never exceeds NUM_STAGES-1.
//   - start held high does not retrigger; only an edge acts.
//   - resetN low mid-game returns to the reset state on the next posedge.
// TESTING
//  1. Reset, start 0->1 -> LOAD 1 cycle (resetN_player=0, resetN_kind=000);
//     then PLAY with enable_kind=001, stage_num=0.
//  2. Defaults, INTER_FRAMES=3: pulse win_stage in PLAY -> stage_done_pulse 1 cycle;
//     after 3 startOfFrame, stage 1 LOAD (resetN_player=1) -> enable_kind=001;
//     stage 2 -> 010; stage 3 -> 100.
//  3. Stage 3 win -> game_won=1, enables 0; start edge -> stage_num=0, game_won=0,
//     resetN_player pulses low.
//  4. win_stage held high into LOAD: first PLAY cycle ignored (no advance);
//     advance on the 2nd cycle.
//  5. pause high in PLAY for 10 cycles with player_dead asserted ->
//     no LOST while paused; on release -> LOST, game_over=1.
//  6. skip edge in INTERMISSION at counter=1 -> immediate LOAD of next stage;
//     skip held high causes no further advance.

Source files
------------

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//   Game-flow controller. Walks a NUM_STAGES-long stage table; each entry picks
//   the enemy kind that runs in that stage (monsters / asteroids / boss / none).
//   Drives per-kind enables and active-low unit resets, handles pause, the
//   cheat skip, a frame-timed intermission between stages and won/over flags.
//
// Parameters
//   NUM_STAGES   number of stages (1..2**STAGE_W)
//   STAGE_W      width of stage_num
//   STAGE_KIND   2 bits per stage, stage i at [2i+1:2i]
//                0=monsters 1=asteroids 2=boss 3=none
//   INTER_FRAMES startOfFrame pulses spent in intermission (0 = no intermission)
//
// Ports
//   clk, resetN        clock, synchronous active-low reset
//   startOfFrame       one-cycle frame strobe
//   start_game         level, rising edge starts / restarts the game
//   pause              level, high freezes play
//   skip_stage         level, rising edge ends the current stage
//   win_stage          level from the active enemy unit
//   player_dead        level, player out of lives
//   enable_player      player unit enable
//   resetN_player      player unit reset (active-low)
//   enable_kind[2:0]   [0]=monsters [1]=asteroids [2]=boss
//   resetN_kind[2:0]   per-kind unit reset (active-low)
//   stage_num          current stage, 0-based
//   stage_done_pulse   one-cycle pulse when a stage is won or skipped
//   game_won           held high in WON
//   game_over          held high in LOST
// -----------------------------------------------------------------------------
module stage_sequencer #(
    parameter int unsigned               NUM_STAGES   = 4,
    parameter int unsigned               STAGE_W      = 3,
    parameter logic [2*NUM_STAGES-1:0]   STAGE_KIND   = 8'b10_01_00_00,
    parameter int unsigned               INTER_FRAMES = 60
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               start_game,
    input  logic               pause,
    input  logic               skip_stage,
    input  logic               win_stage,
    input  logic               player_dead,
    output logic               enable_player,
    output logic               resetN_player,
    output logic [2:0]         enable_kind,
    output logic [2:0]         resetN_kind,
    output logic [STAGE_W-1:0] stage_num,
    output logic               stage_done_pulse,
    output logic               game_won,
    output logic               game_over
);

    localparam int unsigned CNT_W = (INTER_FRAMES > 1) ? $clog2(INTER_FRAMES) : 1;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   =
        (INTER_FRAMES > 0) ? CNT_W'(INTER_FRAMES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_PAUSED,
        S_INTER,
        S_PAUSED_I,
        S_WON,
        S_LOST
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic               guard;
    logic               start_d;
    logic               skip_d;
    logic [9:0]         outs;

    logic               start_rise;
    logic               skip_rise;
    logic [STAGE_W-1:0] stage_inc;

    assign start_rise = start_game & ~start_d;
    assign skip_rise  = skip_stage & ~skip_d;
    assign stage_inc  = stage_num + 1'b1;

    // Unit-control outputs are one flop vector, split onto the ports here.
    assign {enable_player, resetN_player, enable_kind, resetN_kind,
            game_won, game_over} = outs;

    // Enemy-kind one-hot for a stage; kind 3 (player only) enables nothing.
    function automatic logic [2:0] kind_onehot(input logic [STAGE_W-1:0] stg);
        logic [1:0] k;
        logic [2:0] oh;
        k = 2'd3;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            if (stg == STAGE_W'(i)) begin
                k = STAGE_KIND[2*i +: 2];
            end
        end
        case (k)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Output vector for the state being entered, so outputs line up with state.
    function automatic logic [9:0] decode(input state_t st, input logic [STAGE_W-1:0] stg);
        logic       ep;
        logic       rp;
        logic [2:0] ek;
        logic [2:0] rk;
        logic       gw;
        logic       go;
        ep = 1'b0;
        rp = 1'b1;
        ek = 3'b000;
        rk = 3'b111;
        gw = 1'b0;
        go = 1'b0;
        case (st)
            S_IDLE: begin
                rp = 1'b0;
                rk = 3'b000;
            end
            S_LOAD: begin
                // Player survives stage changes; only a fresh game resets it.
                rp = (stg != '0);
                rk = 3'b000;
            end
            S_PLAY: begin
                ep = 1'b1;
                ek = kind_onehot(stg);
            end
            S_INTER: ep = 1'b1;
            S_WON:   gw = 1'b1;
            S_LOST:  go = 1'b1;
            default: ;
        endcase
        return {ep, rp, ek, rk, gw, go};
    endfunction

    // Sequencer state, stage, intermission counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state            <= S_IDLE;
            stage_num        <= '0;
            counter          <= '0;
            guard            <= 1'b0;
            start_d          <= 1'b0;
            skip_d           <= 1'b0;
            outs             <= '0;
            stage_done_pulse <= 1'b0;
        end else begin
            start_d          <= start_game;
            skip_d           <= skip_stage;
            stage_done_pulse <= 1'b0;
            outs             <= decode(state, stage_num);

            case (state)
                S_IDLE: begin
                    if (start_rise) begin
                        state     <= S_LOAD;
                        stage_num <= '0;
                        outs      <= decode(S_LOAD, '0);
                    end
                end

                S_LOAD: begin
                    state <= S_PLAY;
                    guard <= 1'b1;
                    outs  <= decode(S_PLAY, stage_num);
                end

                S_PLAY: begin
                    // win_stage may still be stale from the unit just released
                    // from reset, so it is only trusted after one PLAY cycle.
                    guard <= 1'b0;
                    if (player_dead) begin
                        state <= S_LOST;
                        outs  <= decode(S_LOST, stage_num);
                    end else if (pause) begin
                        state <= S_PAUSED;
                        outs  <= decode(S_PAUSED, stage_num);
                    end else if ((win_stage && !guard) || skip_rise) begin
                        stage_done_pulse <= 1'b1;
                        if (stage_num == LAST_STAGE) begin
                            state <= S_WON;
                            outs  <= decode(S_WON, stage_num);
                        end else if (INTER_FRAMES == 0) begin
                            state     <= S_LOAD;
                            stage_num <= stage_inc;
                            outs      <= decode(S_LOAD, stage_inc);
                        end else begin
                            state   <= S_INTER;
                            counter <= '0;
                            outs    <= decode(S_INTER, stage_num);
                        end
                    end
                end

                S_PAUSED: begin
                    if (!pause) begin
                        state <= S_PLAY;
                        outs  <= decode(S_PLAY, stage_num);
                    end
                end

                S_INTER: begin
                    if (pause) begin
                        state <= S_PAUSED_I;
                        outs  <= decode(S_PAUSED_I, stage_num);
                    end else if (skip_rise) begin
                        state     <= S_LOAD;
                        stage_num <= stage_inc;
                        outs      <= decode(S_LOAD, stage_inc);
                    end else if (startOfFrame) begin
                        if (counter == CNT_LAST) begin
                            state     <= S_LOAD;
                            stage_num <= stage_inc;
                            outs      <= decode(S_LOAD, stage_inc);
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                end

                S_PAUSED_I: begin
                    if (!pause) begin
                        state <= S_INTER;
                        outs  <= decode(S_INTER, stage_num);
                    end
                end

                S_WON, S_LOST: begin
                    if (start_rise) begin
                        state     <= S_LOAD;
                        stage_num <= '0;
                        outs      <= decode(S_LOAD, '0);
                    end
                end

                default: begin
                    state <= S_IDLE;
                    outs  <= decode(S_IDLE, stage_num);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       start_game;
    logic       pause;
    logic       skip_stage;
    logic       win_stage;
    logic       player_dead;
    logic       enable_player;
    logic       resetN_player;
    logic [2:0] enable_kind;
    logic [2:0] resetN_kind;
    logic [2:0] stage_num;
    logic       stage_done_pulse;
    logic       game_won;
    logic       game_over;

    stage_sequencer #(
        .NUM_STAGES   (4),
        .STAGE_W      (3),
        .STAGE_KIND   (8'b10_01_00_00),
        .INTER_FRAMES (3)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .start_game       (start_game),
        .pause            (pause),
        .skip_stage       (skip_stage),
        .win_stage        (win_stage),
        .player_dead      (player_dead),
        .enable_player    (enable_player),
        .resetN_player    (resetN_player),
        .enable_kind      (enable_kind),
        .resetN_kind      (resetN_kind),
        .stage_num        (stage_num),
        .stage_done_pulse (stage_done_pulse),
        .game_won         (game_won),
        .game_over        (game_over)
    );

    always #5 clk = ~clk;

    // {en_player, rstN_player, en_kind, rstN_kind, stage, done, won, over}
    typedef logic [13:0] vec_t;
    typedef struct {
        string tag;
        vec_t  v;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    vec_t obs;
    assign obs = {enable_player, resetN_player, enable_kind, resetN_kind,
                  stage_num, stage_done_pulse, game_won, game_over};

    function automatic vec_t ev(input logic ep, input logic rp, input logic [2:0] ek,
                                input logic [2:0] rk, input logic [2:0] sn,
                                input logic dp, input logic gw, input logic go);
        return {ep, rp, ek, rk, sn, dp, gw, go};
    endfunction

    function automatic vec_t v_rst();
        return ev(1'b0, 1'b0, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic vec_t v_load(input logic [2:0] s);
        return ev(1'b0, (s != 3'd0), 3'b000, 3'b000, s, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic vec_t v_play(input logic [2:0] s, input logic [2:0] k);
        return ev(1'b1, 1'b1, k, 3'b111, s, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic vec_t v_inter(input logic [2:0] s, input logic dp);
        return ev(1'b1, 1'b1, 3'b000, 3'b111, s, dp, 1'b0, 1'b0);
    endfunction
    function automatic vec_t v_paused(input logic [2:0] s);
        return ev(1'b0, 1'b1, 3'b000, 3'b111, s, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic vec_t v_lost(input logic [2:0] s);
        return ev(1'b0, 1'b1, 3'b000, 3'b111, s, 1'b0, 1'b0, 1'b1);
    endfunction

    // Queue the expectation for the next edge, clock, then pop and compare.
    task automatic step(input string tag, input vec_t v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            compared++;
            assert (obs === e.v) else begin
                mismatched++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
            end
        end
    endtask

    // Three frame strobes from a fresh intermission, ending in LOAD of s+1.
    task automatic run_inter(input logic [2:0] s);
        for (int i = 0; i < 3; i++) begin
            startOfFrame = 1'b1;
            if (i == 2) step("inter_end_load", v_load(3'(s + 3'd1)));
            else        step("inter_count", v_inter(s, 1'b0));
            startOfFrame = 1'b0;
            if (i < 2) step("inter_gap", v_inter(s, 1'b0));
        end
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        start_game   = 1'b0;
        pause        = 1'b0;
        skip_stage   = 1'b0;
        win_stage    = 1'b0;
        player_dead  = 1'b0;

        step("reset_a", v_rst());
        step("reset_b", v_rst());
        resetN = 1'b1;
        step("idle", v_rst());

        // Start: one LOAD cycle, then PLAY stage 0 with monsters.
        start_game = 1'b1;
        step("load0", v_load(3'd0));
        step("play0_entry", v_play(3'd0, 3'b001));
        start_game = 1'b0;
        step("play0", v_play(3'd0, 3'b001));

        // Stage progression through intermissions.
        win_stage = 1'b1;
        step("win0_pulse", v_inter(3'd0, 1'b1));
        win_stage = 1'b0;
        step("inter0", v_inter(3'd0, 1'b0));
        run_inter(3'd0);
        step("play1_entry", v_play(3'd1, 3'b001));
        step("play1", v_play(3'd1, 3'b001));

        win_stage = 1'b1;
        step("win1_pulse", v_inter(3'd1, 1'b1));
        win_stage = 1'b0;
        step("inter1", v_inter(3'd1, 1'b0));
        run_inter(3'd1);
        step("play2_entry", v_play(3'd2, 3'b010));
        step("play2", v_play(3'd2, 3'b010));

        win_stage = 1'b1;
        step("win2_pulse", v_inter(3'd2, 1'b1));
        win_stage = 1'b0;
        step("inter2", v_inter(3'd2, 1'b0));
        run_inter(3'd2);
        step("play3_entry", v_play(3'd3, 3'b100));
        step("play3", v_play(3'd3, 3'b100));

        // Last stage won, then restart from WON.
        win_stage = 1'b1;
        step("won", ev(1'b0, 1'b1, 3'b000, 3'b111, 3'd3, 1'b1, 1'b1, 1'b0));
        win_stage = 1'b0;
        step("won_hold", ev(1'b0, 1'b1, 3'b000, 3'b111, 3'd3, 1'b0, 1'b1, 1'b0));
        start_game = 1'b1;
        step("restart_load", v_load(3'd0));
        step("restart_play", v_play(3'd0, 3'b001));
        step("start_held", v_play(3'd0, 3'b001));
        start_game = 1'b0;

        // win_stage held across LOAD: first PLAY cycle must not advance.
        win_stage = 1'b1;
        step("g_win0", v_inter(3'd0, 1'b1));
        step("g_inter_win_ign", v_inter(3'd0, 1'b0));
        run_inter(3'd0);
        step("guard_entry", v_play(3'd1, 3'b001));
        step("guard_ignored", v_play(3'd1, 3'b001));
        step("win_after_guard", v_inter(3'd1, 1'b1));
        win_stage = 1'b0;

        // Skip edge at intermission counter 1; held skip does nothing more.
        step("skip_inter_c0", v_inter(3'd1, 1'b0));
        startOfFrame = 1'b1;
        step("skip_inter_c1", v_inter(3'd1, 1'b0));
        startOfFrame = 1'b0;
        skip_stage = 1'b1;
        step("skip_load2", v_load(3'd2));
        step("skip_play2", v_play(3'd2, 3'b010));
        step("skip_held_a", v_play(3'd2, 3'b010));
        step("skip_held_b", v_play(3'd2, 3'b010));
        skip_stage = 1'b0;

        // player_dead is ignored while paused; LOST follows the release.
        pause = 1'b1;
        step("paused", v_paused(3'd2));
        player_dead = 1'b1;
        for (int i = 0; i < 10; i++) step("paused_dead", v_paused(3'd2));
        pause = 1'b0;
        step("resume", v_play(3'd2, 3'b010));
        step("lost", v_lost(3'd2));
        player_dead = 1'b0;
        step("lost_hold", v_lost(3'd2));

        // Simultaneous skip and pause: pause wins, skip edge is lost.
        start_game = 1'b1;
        step("b_load", v_load(3'd0));
        step("b_play_entry", v_play(3'd0, 3'b001));
        start_game = 1'b0;
        step("b_play", v_play(3'd0, 3'b001));
        skip_stage = 1'b1;
        pause      = 1'b1;
        step("skip_pause", v_paused(3'd0));
        pause = 1'b0;
        step("unpause", v_play(3'd0, 3'b001));
        step("skip_edge_lost", v_play(3'd0, 3'b001));
        skip_stage = 1'b0;

        // Simultaneous win and death: LOST, no done pulse.
        win_stage   = 1'b1;
        player_dead = 1'b1;
        step("win_dead_lost", v_lost(3'd0));
        win_stage   = 1'b0;
        player_dead = 1'b0;

        // Pause during intermission freezes the frame counter.
        start_game = 1'b1;
        step("pi_load", v_load(3'd0));
        step("pi_play_entry", v_play(3'd0, 3'b001));
        start_game = 1'b0;
        step("pi_play", v_play(3'd0, 3'b001));
        skip_stage = 1'b1;
        step("pi_skip_pulse", v_inter(3'd0, 1'b1));
        skip_stage = 1'b0;
        step("pi_inter", v_inter(3'd0, 1'b0));
        pause        = 1'b1;
        startOfFrame = 1'b1;
        step("pi_paused_a", v_paused(3'd0));
        step("pi_paused_b", v_paused(3'd0));
        pause = 1'b0;
        step("pi_resume", v_inter(3'd0, 1'b0));
        step("pi_c1", v_inter(3'd0, 1'b0));
        step("pi_c2", v_inter(3'd0, 1'b0));
        step("pi_load1", v_load(3'd1));
        startOfFrame = 1'b0;
        step("pi_play1", v_play(3'd1, 3'b001));

        // Reset mid-game returns to the reset state.
        resetN = 1'b0;
        step("mid_reset", v_rst());
        resetN = 1'b1;
        step("idle_after_reset", v_rst());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
